// File: rtl/tcad_pkg.sv
// Shared widths and bit positions for the TCAD CGRA host-side interface.
package tcad_pkg;

  localparam int unsigned SPM_INST   = 1;
  localparam int unsigned PE_INST    = 48;
  localparam int unsigned INIT_PE_A  = 9;
  localparam int unsigned H_C_W      = SPM_INST + INIT_PE_A + PE_INST;
  localparam int unsigned A_W        = 10;
  localparam int unsigned EX_BUS     = 2 + A_W + 32;
  localparam int unsigned EX_WEN_BIT = EX_BUS - 1;
  localparam int unsigned EX_REN_BIT = EX_BUS - 2;

endpackage

// File: rtl/delay_line.sv
// Generic DEPTH-stage shift register with synchronous active-low clear.
module delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_comb begin
    stage_d[0] = d_i;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/run_align_delay.sv
// Aligns host-controller word and external bus to the CGRA array start edge.
// RUN_MASK_EN: when defined, the delayed run strobe masks bus wen/ren.
module run_align_delay
  import tcad_pkg::*;
#(
  parameter int unsigned HC_W  = H_C_W,
  parameter int unsigned A_W   = tcad_pkg::A_W,
  parameter int unsigned EX_W  = EX_BUS,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_i,
  input  logic [HC_W-1:0] host_controller_i,
  input  logic [EX_W-1:0] ex_bus_i,
  output logic [HC_W-1:0] host_controller,
  output logic [EX_W-1:0] ex_bus
);

  logic            run_in;
  logic            run_dly;
  logic [EX_W-1:0] bus_dly;
  logic            wen_out;
  logic            ren_out;

  // Only a clean 1 counts as a run; X/Z enters the pipe as 0.
  assign run_in = (run_i === 1'b1);

  delay_line #(
    .WIDTH(1),
    .DEPTH(DEPTH)
  ) u_run_dly (
    .clk_i (clk),
    .clr_ni(rst),
    .d_i   (run_in),
    .q_o   (run_dly)
  );

  delay_line #(
    .WIDTH(HC_W),
    .DEPTH(DEPTH)
  ) u_hc_dly (
    .clk_i (clk),
    .clr_ni(rst),
    .d_i   (host_controller_i),
    .q_o   (host_controller)
  );

  delay_line #(
    .WIDTH(EX_W),
    .DEPTH(DEPTH)
  ) u_bus_dly (
    .clk_i (clk),
    .clr_ni(rst),
    .d_i   (ex_bus_i),
    .q_o   (bus_dly)
  );

  always_comb begin
    wen_out = bus_dly[EX_W-1];
    ren_out = bus_dly[EX_W-2];
`ifdef RUN_MASK_EN
    if (run_dly) begin
      wen_out = 1'b0;
      ren_out = 1'b0;
    end
`endif
  end

`ifndef RUN_MASK_EN
  logic unused_run;
  assign unused_run = run_dly;
`endif

  assign ex_bus = {wen_out, ren_out, bus_dly[A_W+31:0]};

endmodule

// File: tb/tb_run_align_delay.sv
// Scoreboard bench for run_align_delay: driver queues expected words, monitor checks.
module tb_run_align_delay;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned HC_W  = 58;
  localparam int unsigned EX_W  = 44;
`ifdef RUN_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  typedef struct {
    int              due;
    logic [HC_W-1:0] hc;
    logic [EX_W-1:0] bus;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            run_i;
  logic [HC_W-1:0] host_controller_i;
  logic [EX_W-1:0] ex_bus_i;
  logic [HC_W-1:0] host_controller;
  logic [EX_W-1:0] ex_bus;

  exp_t q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  run_align_delay #(
    .HC_W (HC_W),
    .A_W  (10),
    .EX_W (EX_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .run_i            (run_i),
    .host_controller_i(host_controller_i),
    .ex_bus_i         (ex_bus_i),
    .host_controller  (host_controller),
    .ex_bus           (ex_bus)
  );

  function automatic logic [EX_W-1:0] mk_bus(input logic wen, input logic ren,
                                             input logic [9:0] addr, input logic [31:0] data);
    return {wen, ren, addr, data};
  endfunction

  // Drive one cycle of inputs and queue what must appear DEPTH-1 edges later.
  task automatic drive(input logic r, input logic [HC_W-1:0] hc, input logic [EX_W-1:0] bus,
                       input logic rv);
    exp_t e;
    run_i = r;
    host_controller_i = hc;
    ex_bus_i = bus;
    rst = rv;
    @(posedge clk);
    edge_cnt++;
    if (!rv) begin
      q.delete();
      for (int k = 0; k < DEPTH; k++) begin
        e.due = edge_cnt + k;
        e.hc  = '0;
        e.bus = '0;
        q.push_back(e);
      end
    end else begin
      e.due = edge_cnt + DEPTH - 1;
      e.hc  = hc;
      e.bus = bus;
      if (MASK && (r === 1'b1)) begin
        e.bus[EX_W-1] = 1'b0;
        e.bus[EX_W-2] = 1'b0;
      end
      q.push_back(e);
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < edge_cnt) begin
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_word due=%0d now=%0d", e.due, edge_cnt);
    end
    if (q.size() > 0 && q[0].due == edge_cnt) begin
      e = q.pop_front();
      n_checks++;
      if (host_controller !== e.hc) begin
        n_fail++;
        $display("FAIL host_controller edge=%0d got=%h exp=%h", edge_cnt, host_controller, e.hc);
      end
      n_checks++;
      if (ex_bus !== e.bus) begin
        n_fail++;
        $display("FAIL ex_bus edge=%0d got=%h exp=%h", edge_cnt, ex_bus, e.bus);
      end
    end
  end

  initial begin
    logic [HC_W-1:0] hc_a;
    logic [HC_W-1:0] hc_b;
    hc_a = {1'b0, 9'h003, 48'h004708078d9f};
    hc_b = {1'b0, 9'h003, 48'h00000700002f};

    // Reset held with nonzero inputs.
    for (int i = 0; i < 3; i++) drive(1'b1, hc_a, mk_bus(1'b1, 1'b1, 10'h3ff, 32'hdeadbeef), 1'b0);

    // Config stream: 3 cycles of one word then a second word.
    for (int i = 0; i < 3; i++) drive(1'b0, hc_a, '0, 1'b1);
    drive(1'b0, hc_b, '0, 1'b1);

    // 100 back-to-back bus writes.
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, '0, mk_bus(1'b1, 1'b0, 10'(i), 32'(i + 1)), 1'b1);
    end

    // Run collision, then an unmasked follower.
    drive(1'b1, hc_b, mk_bus(1'b1, 1'b0, 10'd5, 32'd6), 1'b1);
    drive(1'b0, hc_a, mk_bus(1'b1, 1'b1, 10'd7, 32'd8), 1'b1);

    // Run held for 3 cycles over read words, then X on run.
    for (int i = 0; i < 3; i++) drive(1'b1, '0, mk_bus(1'b0, 1'b1, 10'(20 + i), 32'(i)), 1'b1);
    drive(1'bx, '0, mk_bus(1'b1, 1'b0, 10'd30, 32'd31), 1'b1);
    drive(1'b0, '0, mk_bus(1'b0, 1'b1, 10'd32, 32'd33), 1'b1);

    // Mid-stream reset: in-flight words must be dropped.
    for (int i = 0; i < 3; i++) drive(1'b0, hc_a, mk_bus(1'b1, 1'b0, 10'(40 + i), 32'(50 + i)), 1'b1);
    drive(1'b0, hc_b, mk_bus(1'b1, 1'b1, 10'd99, 32'd99), 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, hc_b, mk_bus(1'b0, 1'b1, 10'(60 + i), 32'(70 + i)), 1'b1);

    // Drain.
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    #1;
    while (q.size() > 0 && q[0].due <= edge_cnt) begin
      void'(q.pop_front());
      n_checks++;
      n_fail++;
      $display("FAIL drain_leftover now=%0d", edge_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_align_delay.md
# run_align_delay

Input-alignment stage between the host/testbench side and the TCAD CGRA array. It delays the host-controller configuration word and the external memory bus by a fixed number of clock cycles, so both reach the array on the same edge. A run strobe travels through the same pipeline. While the delayed run strobe is high, the external bus read/write enables are suppressed, so no SPM access collides with the array start cycle.

## Interface
Parameters:
- `HC_W`, default 58: host-controller width. 1 init_SPM + 9 init_PE_array + 48 PE instruction.
- `A_W`, default 10: external bus address width.
- `EX_W`, default 44: external bus width, equal to 2 + A_W + 32.
- `DEPTH`, default 2: pipeline latency in cycles. Legal range 1..8.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `run_i`, input, 1: run strobe from the host.
- `host_controller_i`, input, HC_W: `{init_SPM, init_PE_array[8:0], inst[47:0]}`.
- `ex_bus_i`, input, EX_W: `{wen, ren, addr[A_W-1:0], data[31:0]}`.
- `host_controller`, output, HC_W: delayed host-controller word.
- `ex_bus`, output, EX_W: delayed external bus, with wen/ren masked.

## Operation
- Three parallel shift registers of DEPTH stages each: `run_i`, `host_controller_i`, `ex_bus_i`.
- Every cycle when not in reset, stage k takes stage k-1 and stage 0 takes the input.
- `host_controller` is the last stage of the host-controller line, passed through unmodified.
- `ex_bus` is the last stage of the bus line, with these fields:
  - bits [EX_W-1] (wen) and [EX_W-2] (ren) forced to 0 when the last run stage is 1;
  - address and data bits always passed through unmodified.
- The block does no decoding of init or instruction fields and applies no back-pressure.
- An X/Z value on `run_i` is registered as 0 (case-equality check on 1'b1).

## Timing
- Reset: `rst`=0 at a rising edge clears every stage of all three lines to 0.
  - `host_controller` = 0 and `ex_bus` = 0 from the cycle after that edge.
  - Reset in the middle of a stream discards all in-flight words; nothing is replayed.
- Latency: an input sampled at edge N appears on the outputs after edge N+DEPTH-1 and is stable until edge N+DEPTH.
- Throughput: one word per cycle. Back-to-back words are preserved in order with no bubbles.
- Masking uses the same-index run stage, so the mask is cycle-aligned with the bus word sampled together with the `run_i` pulse.
- Simultaneous `run_i`=1 and `wen`=1 in the same input cycle:
  - that bus word emerges with wen=0 and ren=0;
  - its addr/data are intact;
  - the host-controller word of that cycle is unaffected.
- A run held high for M cycles masks exactly M consecutive output bus words.

## Configuration
- `RUN_MASK_EN`, when defined: wen/ren masking as described above. This is the default build.
- When undefined: `ex_bus` is the pure DEPTH-cycle delay of `ex_bus_i`. The run line is still present but has no effect on any output.
- In both builds, latency and reset behaviour are identical.

## Structure
- Shared package `tcad_pkg` holds:
  - constants `SPM_INST`, `PE_INST`=48, `INIT_PE_A`=9, `H_C_W`=58, `A_W`=10, `EX_BUS`=44;
  - bit-index constants `EX_WEN_BIT`=43 and `EX_REN_BIT`=42.
- One generic sub-module `delay_line`:
  - parameters WIDTH and DEPTH;
  - synchronous active-low clear;
  - instantiated three times (run, host controller, bus).
- The masking logic lives in the top level.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with nonzero inputs -> both outputs are 0. Release -> first input word appears exactly DEPTH=2 cycles later.
- Config stream: drive `host_controller_i` with inst 'h004708078d9f, init_row_0=1, init_PE_0=1, for 3 cycles, then 'h00000700002f -> output replays both words, same order and durations, delayed 2 cycles.
- Bus stream: 100 consecutive writes with wen=1, addr=i, data=i+1, `run_i`=0 -> 100 identical words on `ex_bus` after 2 cycles, no gaps.
- Run collision: `run_i`=1 together with wen=1, addr=5, data=6 -> output word has wen=0, ren=0, addr=5, data=6. The next word, with run=0, passes unmasked.
- Macro off: repeat the run-collision case without `RUN_MASK_EN` -> wen=1 is preserved.
- Mid-stream reset: assert `rst`=0 while words are in flight -> outputs are 0 next cycle, and no pre-reset word ever appears.
